// File: rtl/lzw_pkg.sv
// Shared constants and FSM encoding for the LZW byte-reverse stages.
// Used by both the forward and backward byte-reverse blocks.
package lzw_pkg;

   localparam int LZW_MAX_GRP   = 31;
   localparam int LZW_REV_NUM_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_POP     = 2'd2,
      ST_HOLD    = 2'd3
   } lzw_state_e;

endpackage

// File: rtl/lzw_byte_lifo.sv
// Byte stack on a register array; rd_data always shows the top entry.
// Push and pop are never requested in the same cycle.
module lzw_byte_lifo #(
   parameter int DEPTH = 32,
   parameter int SP_W  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [7:0]      wr_data,
   output logic [7:0]      rd_data,
   output logic [SP_W-1:0] sp
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]      mem_q [DEPTH];
   logic [SP_W-1:0] sp_q;
   logic [SP_W-1:0] sp_d;
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   rd_idx;

   always_comb begin
      sp_d = sp_q;
      if (push)
         sp_d = sp_q + SP_W'(1);
      else if (pop)
         sp_d = sp_q - SP_W'(1);
   end

   assign wr_idx  = AW'(sp_q);
   assign rd_idx  = AW'(sp_q - SP_W'(1));
   assign rd_data = mem_q[rd_idx];
   assign sp      = sp_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         sp_q <= '0;
      else
         sp_q <= sp_d;
      if (push)
         mem_q[wr_idx] <= wr_data;
   end

endmodule

// File: rtl/lzw_forward_byte_reverse.sv
// Forward byte reverse: passes plain bytes through and emits marked
// groups in reverse order, tagging each group with its byte count.
module lzw_forward_byte_reverse
   import lzw_pkg::*;
#(
   parameter int MAX_GRP   = LZW_MAX_GRP,
   parameter int REV_NUM_W = LZW_REV_NUM_W,
   parameter int CNT_W     = 16
) (
   input  logic                 I_sys_clk,
   input  logic                 I_sys_rst_n,
   input  logic                 I_state_clr,
   input  logic [7:0]           I_payload_data,
   input  logic                 I_payload_data_en,
   input  logic                 I_payload_rev,
   input  logic                 I_payload_eog,
   output logic                 O_payload_ready,
   output logic [7:0]           O_dictionary_send_data,
   output logic                 O_dictionary_send_data_en,
   output logic                 O_reverse_byte_flag,
   output logic [REV_NUM_W-1:0] O_reverse_byte_num,
   output logic                 O_reverse_byte_num_wren,
   output logic [CNT_W-1:0]     O_grp_cnt,
   output logic [CNT_W-1:0]     O_err_cnt
);

   localparam int SP_W = $clog2(32 + 1);

   lzw_state_e           state_q, state_d;
   logic                 ready_q, ready_d;
   logic [REV_NUM_W-1:0] len_q, len_d;
   logic                 first_q, first_d;
   logic                 hold_flag_q, hold_flag_d;
   logic [7:0]           hold_data_q, hold_data_d;
   logic [7:0]           out_data_q, out_data_d;
   logic                 out_en_q, out_en_d;
   logic                 flag_q, flag_d;
   logic [REV_NUM_W-1:0] num_q, num_d;
   logic                 wren_q, wren_d;
   logic [CNT_W-1:0]     grp_cnt_q, grp_cnt_d;
   logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;

   logic            acc, push, pop, grp_inc, err_inc, full_after;
   logic [7:0]      rd_data;
   logic [SP_W-1:0] sp, sp_inc;

   lzw_byte_lifo #(.DEPTH(32), .SP_W(SP_W)) u_lifo (
      .clk     (I_sys_clk),
      .rst_n   (I_sys_rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (I_payload_data),
      .rd_data (rd_data),
      .sp      (sp)
   );

   assign acc        = I_payload_data_en & ready_q;
   assign sp_inc     = sp + SP_W'(1);
   assign full_after = (sp_inc == SP_W'(MAX_GRP));

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      first_d     = first_q;
      hold_flag_d = hold_flag_q;
      hold_data_d = hold_data_q;
      out_data_d  = out_data_q;
      out_en_d    = 1'b0;
      flag_d      = 1'b0;
      num_d       = '0;
      wren_d      = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      grp_inc     = 1'b0;
      err_inc     = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if (acc && I_payload_rev) begin
               push    = 1'b1;
               state_d = ST_COLLECT;
               if (I_payload_eog || full_after) begin
                  state_d = ST_POP;
                  len_d   = REV_NUM_W'(sp_inc);
                  first_d = 1'b1;
                  err_inc = ~I_payload_eog;
               end
            end else if (acc && state_q == ST_IDLE) begin
               out_en_d   = 1'b1;
               out_data_d = I_payload_data;
            end else if (acc) begin
               // plain byte inside an open group: park it, flush group
               hold_data_d = I_payload_data;
               hold_flag_d = 1'b1;
               state_d     = ST_POP;
               len_d       = REV_NUM_W'(sp);
               first_d     = 1'b1;
               err_inc     = 1'b1;
            end
         end
         ST_POP: begin
            pop        = 1'b1;
            out_en_d   = 1'b1;
            out_data_d = rd_data;
            flag_d     = first_q;
            wren_d     = first_q;
            num_d      = first_q ? len_q : '0;
            first_d    = 1'b0;
            if (sp == SP_W'(1)) begin
               grp_inc = 1'b1;
               state_d = hold_flag_q ? ST_HOLD : ST_IDLE;
            end
         end
         ST_HOLD: begin
            out_en_d    = 1'b1;
            out_data_d  = hold_data_q;
            hold_flag_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
   end

   always_comb begin
      grp_cnt_d = grp_cnt_q;
      err_cnt_d = err_cnt_q;
      if (I_state_clr) begin
         grp_cnt_d = '0;
         err_cnt_d = '0;
      end else begin
         if (grp_inc && !(&grp_cnt_q))
            grp_cnt_d = grp_cnt_q + CNT_W'(1);
         if (err_inc && !(&err_cnt_q))
            err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge I_sys_clk) begin
      if (!I_sys_rst_n) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         len_q       <= '0;
         first_q     <= 1'b0;
         hold_flag_q <= 1'b0;
         hold_data_q <= '0;
         out_data_q  <= '0;
         out_en_q    <= 1'b0;
         flag_q      <= 1'b0;
         num_q       <= '0;
         wren_q      <= 1'b0;
         grp_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         len_q       <= len_d;
         first_q     <= first_d;
         hold_flag_q <= hold_flag_d;
         hold_data_q <= hold_data_d;
         out_data_q  <= out_data_d;
         out_en_q    <= out_en_d;
         flag_q      <= flag_d;
         num_q       <= num_d;
         wren_q      <= wren_d;
         grp_cnt_q   <= grp_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign O_payload_ready           = ready_q;
   assign O_dictionary_send_data    = out_data_q;
   assign O_dictionary_send_data_en = out_en_q;
   assign O_reverse_byte_flag       = flag_q;
   assign O_reverse_byte_num        = num_q;
   assign O_reverse_byte_num_wren   = wren_q;
   assign O_grp_cnt                 = grp_cnt_q;
   assign O_err_cnt                 = err_cnt_q;

endmodule

// File: tb/tb_lzw_forward_byte_reverse.sv
// Bench for lzw_forward_byte_reverse: directed steps plus random traffic
// scored against a group-level stream model.
module tb_lzw_forward_byte_reverse;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] din = '0;
   logic       den = 1'b0;
   logic       drev = 1'b0;
   logic       deog = 1'b0;
   logic       ready;
   logic [7:0] dout;
   logic       dout_en;
   logic       flag;
   logic [4:0] num;
   logic       wren;
   logic [15:0] grp_cnt;
   logic [15:0] err_cnt;

   always #2 clk = ~clk;

   lzw_forward_byte_reverse dut (
      .I_sys_clk                 (clk),
      .I_sys_rst_n               (rst_n),
      .I_state_clr               (clr),
      .I_payload_data            (din),
      .I_payload_data_en         (den),
      .I_payload_rev             (drev),
      .I_payload_eog             (deog),
      .O_payload_ready           (ready),
      .O_dictionary_send_data    (dout),
      .O_dictionary_send_data_en (dout_en),
      .O_reverse_byte_flag       (flag),
      .O_reverse_byte_num        (num),
      .O_reverse_byte_num_wren   (wren),
      .O_grp_cnt                 (grp_cnt),
      .O_err_cnt                 (err_cnt)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic [4:0] n;
   } out_t;

   int         n_cmp = 0;
   int         n_err = 0;
   out_t       exp_q[$];
   logic [7:0] grp_m[$];
   int         m_grp = 0;
   int         m_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void close_grp();
      int sz = grp_m.size();
      for (int i = sz - 1; i >= 0; i--) begin
         out_t e;
         e.d = grp_m[i];
         e.f = (i == sz - 1);
         e.n = 5'(sz);
         exp_q.push_back(e);
      end
      grp_m.delete();
      m_grp++;
   endfunction

   function automatic void model(input logic [7:0] d, input logic r,
                                 input logic e);
      out_t o;
      if (r) begin
         grp_m.push_back(d);
         if (e || grp_m.size() == 31) begin
            if (!e) m_err++;
            close_grp();
         end
      end else begin
         if (grp_m.size() > 0) begin
            m_err++;
            close_grp();
         end
         o.d = d;
         o.f = 1'b0;
         o.n = '0;
         exp_q.push_back(o);
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n && dout_en) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", {24'd0, dout}, 32'hFFFF_FFFF);
         end else begin
            out_t e;
            e = exp_q.pop_front();
            chk("out_data", 32'(dout), 32'(e.d));
            chk("out_flag", 32'(flag), 32'(e.f));
            chk("out_wren", 32'(wren), 32'(e.f));
            if (e.f) chk("out_num", 32'(num), 32'(e.n));
         end
      end else if (rst_n) begin
         chk("idle_wren", 32'(wren), 32'd0);
      end
   end

   task automatic send(input logic [7:0] d, input logic r, input logic e);
      int w = 0;
      @(negedge clk);
      while (!ready) begin
         w++;
         if (w > 100) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            return;
         end
         @(negedge clk);
      end
      din  = d;
      drev = r;
      deog = e;
      den  = 1'b1;
      model(d, r, e);
      @(posedge clk);
      #1;
      den  = 1'b0;
      drev = 1'b0;
      deog = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_en"}, 32'(dout_en), 32'd0);
      chk({tag, "_data"}, 32'(dout), 32'd0);
      chk({tag, "_flag"}, 32'(flag), 32'd0);
      chk({tag, "_wren"}, 32'(wren), 32'd0);
      chk({tag, "_num"}, 32'(num), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_grp"}, 32'(grp_cnt), 32'd0);
      chk({tag, "_err"}, 32'(err_cnt), 32'd0);
   endtask

   initial begin
      int lo;
      // reset state
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);

      // pass-through, latency 1
      send(8'h11, 1'b0, 1'b0);
      chk("pt_lat_en", 32'(dout_en), 32'd1);
      chk("pt_lat_d", 32'(dout), 32'h11);
      send(8'h22, 1'b0, 1'b0);
      chk("pt_lat_d2", 32'(dout), 32'h22);
      send(8'h33, 1'b0, 1'b0);
      chk("pt_lat_d3", 32'(dout), 32'h33);
      drain();
      chk("pt_grp", 32'(grp_cnt), 32'd0);

      // group of 4
      for (int i = 0; i < 4; i++)
         send(8'hA0 + 8'(i), 1'b1, i == 3);
      lo = 0;
      chk("g4_ready_low", 32'(ready), 32'd0);
      forever begin
         @(negedge clk);
         if (ready || lo > 50) break;
         lo++;
      end
      chk("g4_low_cycles", 32'(lo), 32'd4);
      drain();
      chk("g4_grp", 32'(grp_cnt), 32'd1);

      // single-byte group then pass-through
      send(8'h5A, 1'b1, 1'b1);
      send(8'h6B, 1'b0, 1'b0);
      drain();
      chk("g1_grp", 32'(grp_cnt), 32'd2);

      // overflow: forced close at 31 bytes
      for (int i = 0; i < 40; i++)
         send(8'(i), 1'b1, 1'b0);
      drain();
      chk("ovf_err", 32'(err_cnt), 32'd1);
      chk("ovf_grp", 32'(grp_cnt), 32'd3);
      chk("ovf_open", 32'(grp_m.size()), 32'd9);
      send(8'h28, 1'b1, 1'b1);
      drain();
      chk("ovf_grp2", 32'(grp_cnt), 32'd4);

      // counter clear leaves datapath alone
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_grp = 0;
      m_err = 0;
      chk("clr_grp", 32'(grp_cnt), 32'd0);
      chk("clr_err", 32'(err_cnt), 32'd0);

      // protocol error with held byte
      send(8'hC0, 1'b1, 1'b0);
      send(8'hC1, 1'b1, 1'b0);
      send(8'hD0, 1'b0, 1'b0);
      drain();
      chk("perr_err", 32'(err_cnt), 32'd1);
      chk("perr_grp", 32'(grp_cnt), 32'd1);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) @(negedge clk);
         send(8'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) == 0);
      end
      send(8'hEE, 1'b0, 1'b0);
      drain();
      chk("rnd_grp", 32'(grp_cnt), 32'(m_grp));
      chk("rnd_err", 32'(err_cnt), 32'(m_err));

      // reset in the middle of popping a 10-byte group
      for (int i = 0; i < 10; i++)
         send(8'h80 + 8'(i), 1'b1, i == 9);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b0;
      clr   = 1'b1;
      exp_q.delete();
      grp_m.delete();
      repeat (2) @(negedge clk);
      chk_zero("midrst");
      rst_n = 1'b1;
      clr   = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ready", 32'(ready), 32'd1);
      repeat (20) @(negedge clk);
      chk("midrst_grp", 32'(grp_cnt), 32'd0);
      chk("midrst_err", 32'(err_cnt), 32'd0);
      chk("midrst_quiet", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
